// File: rtl/fp_addsub_issue.sv
// fp_addsub_issue: decodes FADD.S/FSUB.S requests and buffers them in a FIFO.
// Decode is stored on push; operands are unpacked from the head entry.
module fp_addsub_issue #(
    parameter int SIG_BITS = 23,
    parameter int EXP_BITS = 8,
    parameter int TAG_BITS = 5,
    parameter int DEPTH    = 4,
    localparam int W  = SIG_BITS + EXP_BITS + 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_funct7,
    input  logic [2:0]          in_rm,
    input  logic [W-1:0]        in_rs1,
    input  logic [W-1:0]        in_rs2,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_opcode,
    output logic                out_sign1,
    output logic                out_sign2,
    output logic [EXP_BITS-1:0] out_exp1,
    output logic [EXP_BITS-1:0] out_exp2,
    output logic [SIG_BITS-1:0] out_sig1,
    output logic [SIG_BITS-1:0] out_sig2,
    output logic [2:0]          out_rm,
    output logic [TAG_BITS-1:0] out_tag,
    output logic                out_illegal,
    output logic [CW-1:0]       count
);

    typedef struct packed {
        logic                opcode;
        logic                illegal;
        logic [2:0]          rm;
        logic [TAG_BITS-1:0] tag;
        logic [W-1:0]        rs1;
        logic [W-1:0]        rs2;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          dec_opcode;
    logic          dec_illegal;

    assign in_ready  = reset_n && (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        dec_opcode  = 1'b0;
        dec_illegal = 1'b0;
        unique case (1'b1)
            (in_funct7 == 7'b0000000): dec_opcode = 1'b0;
            (in_funct7 == 7'b0000100): dec_opcode = 1'b1;
            default:                   dec_illegal = 1'b1;
        endcase
        // rm 101/110 are reserved; 111 (dynamic) is resolved downstream
        if (in_rm == 3'b101 || in_rm == 3'b110)
            dec_illegal = 1'b1;
    end

    always_comb begin
        wr_entry         = '0;
        wr_entry.opcode  = dec_opcode;
        wr_entry.illegal = dec_illegal;
        wr_entry.rm      = in_rm;
        wr_entry.tag     = in_tag;
        wr_entry.rs1     = in_rs1;
        wr_entry.rs2     = in_rs2;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign head        = mem[rd_ptr];
    assign out_opcode  = head.opcode;
    assign out_illegal = head.illegal;
    assign out_rm      = head.rm;
    assign out_tag     = head.tag;
    assign out_sign1   = head.rs1[W-1];
    assign out_exp1    = head.rs1[W-2:SIG_BITS];
    assign out_sig1    = head.rs1[SIG_BITS-1:0];
    assign out_sign2   = head.rs2[W-1];
    assign out_exp2    = head.rs2[W-2:SIG_BITS];
    assign out_sig2    = head.rs2[SIG_BITS-1:0];

endmodule

// File: tb/tb_fp_addsub_issue.sv
// tb_fp_addsub_issue: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference of the issue FIFO.
module tb_fp_addsub_issue;

    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [6:0]  in_funct7 = 0;
    logic [2:0]  in_rm = 0;
    logic [31:0] in_rs1 = 0;
    logic [31:0] in_rs2 = 0;
    logic [4:0]  in_tag = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic        out_opcode;
    logic        out_sign1, out_sign2;
    logic [7:0]  out_exp1, out_exp2;
    logic [22:0] out_sig1, out_sig2;
    logic [2:0]  out_rm;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [2:0]  count;

    fp_addsub_issue dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct7(in_funct7), .in_rm(in_rm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode),
        .out_sign1(out_sign1), .out_sign2(out_sign2),
        .out_exp1(out_exp1), .out_exp2(out_exp2),
        .out_sig1(out_sig1), .out_sig2(out_sig2),
        .out_rm(out_rm), .out_tag(out_tag),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          opcode;
        bit          illegal;
        bit [2:0]    rm;
        bit [4:0]    tag;
        bit          sign1, sign2;
        bit [7:0]    exp1, exp2;
        bit [22:0]   sig1, sig2;
    } exp_t;

    typedef struct {
        bit [6:0]  f7;
        bit [2:0]  rm;
        bit [31:0] rs1, rs2;
        bit [4:0]  tag;
        bit        op, ill, s1;
        bit [7:0]  e1;
        bit [22:0] g1;
        bit        s2;
        bit [7:0]  e2;
        bit [22:0] g2;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t mq[$];
    bit [4:0] pop_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_decode(bit [6:0] f7, bit [2:0] rm,
                                        bit [31:0] a, bit [31:0] b,
                                        bit [4:0] tag);
        exp_t r;
        r.opcode  = (f7 == 7'd4);
        r.illegal = !(f7 == 7'd0 || f7 == 7'd4) || rm == 3'd5 || rm == 3'd6;
        r.rm      = rm;
        r.tag     = tag;
        r.sign1   = (a >= 32'h8000_0000);
        r.exp1    = 8'((a / 32'd8388608) % 32'd256);
        r.sig1    = 23'(a % 32'd8388608);
        r.sign2   = (b >= 32'h8000_0000);
        r.exp2    = 8'((b / 32'd8388608) % 32'd256);
        r.sig2    = 23'(b % 32'd8388608);
        return r;
    endfunction

    task automatic compare_model();
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() != DEPTH);
        if (mq.size() != 0) begin
            chk("head_opcode", out_opcode, mq[0].opcode);
            chk("head_illegal", out_illegal, mq[0].illegal);
            chk("head_rm", out_rm, mq[0].rm);
            chk("head_tag", out_tag, mq[0].tag);
            chk("head_sign1", out_sign1, mq[0].sign1);
            chk("head_exp1", out_exp1, mq[0].exp1);
            chk("head_sig1", out_sig1, mq[0].sig1);
            chk("head_sign2", out_sign2, mq[0].sign2);
            chk("head_exp2", out_exp2, mq[0].exp2);
            chk("head_sig2", out_sig2, mq[0].sig2);
        end
    endtask

    // Called at a negedge with inputs set; advances one edge, checks at next negedge.
    task automatic step();
        bit   push, pop;
        exp_t e;
        push = in_valid && (mq.size() != DEPTH);
        pop  = (mq.size() != 0) && out_ready;
        e = ref_decode(in_funct7, in_rm, in_rs1, in_rs2, in_tag);
        if (out_valid && out_ready)
            pop_log.push_back(out_tag);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_req(bit [6:0] f7, bit [2:0] rm, bit [31:0] a,
                           bit [31:0] b, bit [4:0] tag);
        in_funct7 = f7;
        in_rm     = rm;
        in_rs1    = a;
        in_rs2    = b;
        in_tag    = tag;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{7'h04, 3'd0, 32'hC0490FDB, 32'h3F800000, 5'd7,
                    1, 0, 1, 8'h80, 23'h490FDB, 0, 8'h7F, 23'h0};
        vecs[1] = '{7'h08, 3'd0, 32'h3F800000, 32'h40000000, 5'd3,
                    0, 1, 0, 8'h7F, 23'h0, 0, 8'h80, 23'h0};
        vecs[2] = '{7'h00, 3'd5, 32'h7F800000, 32'hFFC00001, 5'd12,
                    0, 1, 0, 8'hFF, 23'h0, 1, 8'hFF, 23'h400001};
        vecs[3] = '{7'h00, 3'd7, 32'h00000001, 32'h80000000, 5'd31,
                    0, 0, 0, 8'h00, 23'h1, 1, 8'h00, 23'h0};
        vecs[4] = '{7'h04, 3'd6, 32'hBF7FFFFF, 32'h00800000, 5'd0,
                    1, 1, 1, 8'h7E, 23'h7FFFFF, 0, 8'h01, 23'h0};
        vecs[5] = '{7'h20, 3'd1, 32'h41200000, 32'hC2F60000, 5'd21,
                    0, 1, 0, 8'h82, 23'h200000, 1, 8'h85, 23'h760000};

        // Reset held for 3 cycles
        reset_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_fields", {out_opcode, out_illegal, out_sign1, out_sign2,
                           out_exp1, out_exp2, out_rm, out_tag}, 0);
        chk("rst_sigs", {out_sig1, out_sig2}, 0);
        reset_n = 1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Table vectors: push into empty FIFO, check fields, pop
        foreach (vecs[i]) begin
            @(negedge clk);
            set_req(vecs[i].f7, vecs[i].rm, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
            in_valid  = 1;
            out_ready = 0;
            step();
            in_valid = 0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_opcode", i), out_opcode, vecs[i].op);
            chk($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].ill);
            chk($sformatf("vec%0d_op1", i), {out_sign1, out_exp1, out_sig1},
                {vecs[i].s1, vecs[i].e1, vecs[i].g1});
            chk($sformatf("vec%0d_op2", i), {out_sign2, out_exp2, out_sig2},
                {vecs[i].s2, vecs[i].e2, vecs[i].g2});
            chk($sformatf("vec%0d_tag_rm", i), {out_tag, out_rm},
                {vecs[i].tag, vecs[i].rm});
            out_ready = 1;
            step();
            out_ready = 0;
        end

        // Full and wrap: tags 1..5 with in_valid held
        begin
            int next_tag = 1;
            pop_log.delete();
            out_ready = 0;
            in_valid  = 1;
            for (int c = 0; c < 5; c++) begin
                set_req(7'h00, 3'd0, $urandom, $urandom, 5'(next_tag));
                if (in_ready) next_tag++;
                step();
            end
            chk("full_count", count, 4);
            chk("full_in_ready", in_ready, 0);
            chk("full_head_tag", out_tag, 1);
            out_ready = 1;
            for (int c = 0; c < 20 && pop_log.size() < 5; c++) begin
                if (next_tag > 5) in_valid = 0;
                set_req(7'h00, 3'd0, $urandom, $urandom, 5'(next_tag));
                if (in_valid && in_ready) next_tag++;
                step();
            end
            in_valid = 0;
            chk("wrap_pop_count", pop_log.size(), 5);
            for (int k = 0; k < 5 && k < pop_log.size(); k++)
                chk($sformatf("wrap_order%0d", k), pop_log[k], k + 1);
            out_ready = 0;
        end

        // Simultaneous push/pop at count 2
        begin
            pop_log.delete();
            in_valid = 1;
            for (int c = 0; c < 2; c++) begin
                set_req(7'h04, 3'd1, $urandom, $urandom, 5'(10 + c));
                step();
            end
            chk("pp_pre_count", count, 2);
            out_ready = 1;
            for (int c = 0; c < 10; c++) begin
                set_req(7'h04, 3'd1, $urandom, $urandom, 5'(12 + c));
                step();
                chk($sformatf("pp_count%0d", c), count, 2);
            end
            for (int k = 0; k < 10 && k < pop_log.size(); k++)
                chk($sformatf("pp_order%0d", k), pop_log[k], 10 + k);
            in_valid = 0;
            for (int c = 0; c < 4; c++) step();
            out_ready = 0;
        end

        // Flush wins over a same-cycle push
        begin
            in_valid = 1;
            for (int c = 0; c < 3; c++) begin
                set_req(7'h00, 3'd0, $urandom, $urandom, 5'(c + 1));
                step();
            end
            chk("fl_pre_count", count, 3);
            flush = 1;
            set_req(7'h00, 3'd0, 32'h1234_5678, 32'h0, 5'd30);
            step();
            flush = 0;
            in_valid = 0;
            chk("fl_count", count, 0);
            chk("fl_out_valid", out_valid, 0);
            pop_log.delete();
            in_valid = 1;
            set_req(7'h00, 3'd0, 32'h3F800000, 32'h0, 5'd9);
            step();
            in_valid  = 0;
            out_ready = 1;
            step();
            step();
            chk("fl_after_count", pop_log.size(), 1);
            if (pop_log.size() > 0)
                chk("fl_after_tag", pop_log[0], 9);
            out_ready = 0;
        end

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            int sel = $urandom_range(0, 3);
            bit [6:0] f7;
            f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h04 : 7'($urandom);
            set_req(f7, 3'($urandom), $urandom, $urandom, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 0;

        // Mid-operation reset discards everything
        out_ready = 0;
        in_valid  = 1;
        for (int c = 0; c < 3; c++) begin
            set_req(7'h04, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
            step();
        end
        reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        chk("mrst_count", count, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_fields", {out_opcode, out_illegal, out_sign1, out_sign2,
                            out_exp1, out_exp2, out_rm, out_tag}, 0);
        chk("mrst_sigs", {out_sig1, out_sig2}, 0);
        in_valid = 0;
        reset_n  = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
